// File: rtl/serial_sub4_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default counter width.
// Imported by the top level; holds no logic of its own.
package serial_sub4_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_SHIFT = SHIFT,
    S_DONE  = DONE
  } state_e;

  localparam int WIDTH_DEF = 4;
  localparam int CW        = $clog2(WIDTH_DEF);

endpackage

// File: rtl/serial_sub4_full_sub1.sv
// One-bit full subtractor, purely combinational (zero latency, no flow control).
// d = x - y - bin, bout set when the subtraction borrows.
module full_sub1 (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial a - b - b_in, LSB first; done pulses WIDTH+1 cycles after the accepted start.
// No backpressure: start is only sampled in IDLE, requests while busy are dropped.
module serial_sub4
  import serial_sub4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CNTW = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  res_sr_q, res_sr_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              brw_q, brw_d;
  logic              b_out_q, b_out_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              d_bit;
  logic              bout_bit;

  full_sub1 u_full_sub1 (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (brw_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    b_out_d  = b_out_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = b_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_sr_d = {d_bit, res_sr_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        brw_d    = bout_bit;
        cnt_d    = cnt_q + 1'b1;
        // Capture the result on the final bit so diff/b_out are valid while done is high.
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          diff_d  = res_sr_d;
          b_out_d = bout_bit;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      b_out_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      diff_q   <= diff_d;
      brw_q    <= brw_d;
      b_out_q  <= b_out_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Directed and exhaustive checks of serial_sub4 against an a-b-b_in model.
// Expected results are queued at accept time and popped on each done pulse.
module tb_serial_sub4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       b_in;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       b_out;

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  serial_sub4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  function automatic logic [4:0] model(input logic [3:0] x, input logic [3:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {4'b0, bi};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [4:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 5'bxxxxx;
  endfunction

  // Drive one request at a negedge while IDLE; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic bi);
    start = 1'b1;
    a     = x;
    b     = y;
    b_in  = bi;
    exp_q.push_back(model(x, y, bi));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    logic       found;
    logic [4:0] e;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (done) begin
        found = 1'b1;
        e     = pop_exp();
        chk({tag, "_diff"}, 8'(diff), 8'(e[3:0]));
        chk({tag, "_bout"}, 8'(b_out), 8'(e[4]));
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 8'(found), 8'd1);
  endtask

  initial begin
    logic [4:0] e;
    int         ndone;
    int         idx;
    bit         fin;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_diff", 8'(diff), 8'd0);
    chk("rst_bout", 8'(b_out), 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // 9 - 3: cycle-accurate done/busy profile after the accept edge
    issue(4'd9, 4'd3, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t1_done_k%0d", k), 8'(done), 8'(k == 4));
      chk($sformatf("t1_busy_k%0d", k), 8'(busy), 8'(k <= 4));
      if (k == 4) begin
        e = pop_exp();
        chk("t1_diff", 8'(diff), 8'(e[3:0]));
        chk("t1_diff_const", 8'(diff), 8'd6);
        chk("t1_bout", 8'(b_out), 8'(e[4]));
      end
      @(negedge clk);
    end

    issue(4'd3, 4'd9, 1'b1);
    wait_result("t2");
    repeat (3) @(negedge clk);
    chk("t2_hold", 8'(diff), 8'h9);
    issue(4'd0, 4'd0, 1'b1);
    chk("t3_not_cleared_on_start", 8'(diff), 8'h9);
    wait_result("t3a");
    chk("t3a_const", 8'({b_out, diff}), 8'h1F);
    issue(4'hF, 4'hF, 1'b0);
    wait_result("t3b");
    chk("t3b_const", 8'({b_out, diff}), 8'h00);

    // start re-asserted with different operands while busy must be ignored
    start = 1'b1;
    a     = 4'd9;
    b     = 4'd3;
    b_in  = 1'b0;
    exp_q.push_back(model(4'd9, 4'd3, 1'b0));
    @(negedge clk);
    a = 4'd1;
    b = 4'd1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        ndone++;
        e = pop_exp();
        chk("t4_diff", 8'(diff), 8'(e[3:0]));
        chk("t4_bout", 8'(b_out), 8'(e[4]));
      end
      @(negedge clk);
    end
    chk("t4_one_done", 8'(ndone), 8'd1);
    chk("t4_queue_empty", 8'(exp_q.size()), 8'd0);

    // reset mid-operation aborts it
    start = 1'b1;
    a     = 4'd9;
    b     = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", 8'(busy), 8'd0);
    chk("t5_done", 8'(done), 8'd0);
    chk("t5_diff", 8'(diff), 8'd0);
    chk("t5_bout", 8'(b_out), 8'd0);
    // start coincident with reset is dropped
    start = 1'b1;
    a     = 4'd7;
    b     = 4'd1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("t5_rst_start_busy0", 8'(busy), 8'd0);
    @(negedge clk);
    chk("t5_rst_start_busy1", 8'(busy), 8'd0);
    issue(4'd5, 4'd2, 1'b0);
    wait_result("t5_fresh");
    chk("t5_fresh_const", 8'(diff), 8'd3);

    // exhaustive back-to-back sweep with start held high
    idx   = 0;
    ndone = 0;
    fin   = 1'b0;
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (done) begin
        ndone++;
        e = pop_exp();
        chk("sweep", 8'({b_out, diff}), 8'(e));
      end
      if (!busy) begin
        if (idx < 512) begin
          start = 1'b1;
          a     = 4'(idx >> 5);
          b     = 4'(idx >> 1);
          b_in  = idx[0];
          exp_q.push_back(model(4'(idx >> 5), 4'(idx >> 1), idx[0]));
          idx++;
        end else begin
          start = 1'b0;
          if (exp_q.size() == 0) fin = 1'b1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("sweep_finished", 8'(fin), 8'd1);
    chk("sweep_done_count_lo", 8'(ndone), 8'(512));
    chk("sweep_done_count_hi", 8'(ndone >> 8), 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
